// File: rtl/mips_exc_ctrl.sv
// mips_exc_ctrl: pipeline exception/interrupt sequencer; irq service enabled by `define EXC_IRQ_EN
module mips_exc_ctrl #(
  parameter int MEM_SIZE = 512,
  parameter int EXC_ADDR = MEM_SIZE - 120,
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_ovf,
  input  logic [31:0]        ex_pc,
  input  logic               id_illegal,
  input  logic [31:0]        id_pc,
  input  logic               id_eret,
  input  logic               irq,
  output logic               pc_sel,
  output logic [31:0]        pc_redirect,
  output logic               flush_if,
  output logic               flush_id,
  output logic               flush_ex,
  output logic [31:0]        epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               in_handler,
  output logic               dbl_fault
);
  typedef enum logic [1:0] {IDLE, REDIR, HANDLER, RETURN} state_t;
  state_t state;
  logic irq_ok;
  logic fault;
`ifdef EXC_IRQ_EN
  assign irq_ok = irq;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_ok = 1'b0;
`endif
  assign fault = ex_ovf | id_illegal;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc_sel <= 1'b0;
      pc_redirect <= '0;
      flush_if <= 1'b0;
      flush_id <= 1'b0;
      flush_ex <= 1'b0;
      epc <= '0;
      cause <= '0;
      in_handler <= 1'b0;
      dbl_fault <= 1'b0;
    end else begin
      pc_sel <= 1'b0;
      flush_if <= 1'b0;
      flush_id <= 1'b0;
      flush_ex <= 1'b0;
      // any fault while the handler owns the pipeline is unrecoverable: flag it
      if (state != IDLE && fault) dbl_fault <= 1'b1;
      case (state)
        IDLE: if (fault || irq_ok) begin
          state <= REDIR;
          pc_sel <= 1'b1;
          pc_redirect <= 32'(EXC_ADDR);
          flush_if <= 1'b1;
          flush_id <= 1'b1;
          flush_ex <= ex_ovf;
          in_handler <= 1'b1;
          epc <= ex_ovf ? ex_pc : id_pc;
          cause <= ex_ovf ? CAUSE_W'(12) : id_illegal ? CAUSE_W'(10) : '0;
        end
        REDIR: state <= HANDLER;
        HANDLER: if (!fault && id_eret) begin
          state <= RETURN;
          pc_sel <= 1'b1;
          flush_if <= 1'b1;
          // faults skip the offending instruction, interrupts re-execute it
          pc_redirect <= (cause == '0) ? epc : epc + 32'd4;
        end
        RETURN: begin
          state <= IDLE;
          in_handler <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mips_exc_ctrl.md
Name: mips_exc_ctrl

Overview:
- Exception/interrupt sequencer for the 5-stage pipelined MIPS CPU.
- Collects arithmetic overflow (EX), illegal opcode (ID) and an external interrupt.
- Flushes the affected pipeline stages, redirects fetch to the exception vector and records EPC and cause.
- Sequences the return to normal flow on ERET. Sits beside the PC-select mux and the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
- MEM_SIZE, 512: instruction memory size in bytes.
- EXC_ADDR, MEM_SIZE-120: exception vector. The last 30 instruction slots are reserved for the handler.
- CAUSE_W, 4: width of the cause code.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ex_ovf  in  1  overflow from the instruction currently in EX.
- ex_pc  in  32  PC of the instruction in EX.
- id_illegal  in  1  undecodable opcode in ID.
- id_pc  in  32  PC of the instruction in ID.
- id_eret  in  1  ERET decoded in ID.
- irq  in  1  external interrupt request, level-sensitive.
- pc_sel  out  1  1 = fetch must load pc_redirect next edge.
- pc_redirect  out  32  target PC.
- flush_if  out  1  squash IF/ID register.
- flush_id  out  1  squash ID/EX register.
- flush_ex  out  1  squash EX/MEM register.
- epc  out  32  saved resume PC.
- cause  out  CAUSE_W  last cause code: 0 = irq, 10 = illegal, 12 = overflow.
- in_handler  out  1  handler executing; further events masked.
- dbl_fault  out  1  sticky; exception raised while in_handler.

Behaviour:
- Reset (synchronous): state IDLE; pc_sel, all flush_*, in_handler and dbl_fault = 0; epc = 0; cause = 0; pc_redirect = 0.
- States: IDLE, REDIR, HANDLER, RETURN.
- IDLE: samples events every cycle. Priority: ex_ovf > id_illegal > irq; the older pipeline stage wins.
  - ex_ovf: epc <= ex_pc, cause <= 12, next state REDIR, flush mask = IF, ID, EX.
  - id_illegal: epc <= id_pc, cause <= 10, next state REDIR, flush mask = IF, ID.
  - irq (no fault present): epc <= id_pc, cause <= 0, next state REDIR, flush mask = IF, ID.
  - id_eret in IDLE is ignored: no redirect, no state change.
- REDIR (exactly 1 cycle):
  - pc_sel = 1, pc_redirect = EXC_ADDR.
  - The latched flush mask is driven for this cycle.
  - in_handler = 1 from this cycle onward.
  - Next state HANDLER.
- Latency: event sampled at edge N; redirect and flush are visible during cycle N+1; the fetch of EXC_ADDR occurs at edge N+2.
- HANDLER:
  - in_handler = 1 and irq is masked.
  - ex_ovf or id_illegal sets dbl_fault = 1 (sticky until reset); epc and cause are not modified and the state stays HANDLER.
  - id_eret: next state RETURN.
  - If ERET and a fault occur in the same cycle, the fault wins: dbl_fault is set and ERET is ignored.
- RETURN (exactly 1 cycle):
  - pc_sel = 1, flush_if = 1.
  - pc_redirect = epc + 4 when cause is 10 or 12 (skip the faulting instruction); = epc when cause = 0 (resume the interrupted instruction).
  - epc + 4 wraps modulo 2^32.
  - in_handler is cleared at the end of the cycle; next state IDLE.
- An irq still asserted on the first IDLE cycle after RETURN is taken normally (back-to-back service is allowed).
- pc_sel and flush_* are never asserted outside REDIR and RETURN.
- epc and cause hold their values until the next accepted event.
- Reset asserted in any state overrides everything; outputs read reset values on the next cycle.
- All outputs are registered; there is no combinational path from input to output.

Optional Feature:
- Macro EXC_IRQ_EN.
  - Defined: irq behaves as described above.
  - Undefined: the irq port remains present but is ignored, cause 0 is never produced, and only ex_ovf and id_illegal trigger REDIR.

Test Plan:
- Reset for 2 cycles, then idle 3 cycles -> all outputs 0, state IDLE.
- ex_ovf=1, ex_pc=0x10 for 1 cycle -> next cycle pc_sel=1, pc_redirect=392, flush_if, flush_id and flush_ex all = 1, epc=0x10, cause=12. Then id_eret -> RETURN cycle with pc_redirect=0x14, flush_if=1; in_handler=0 afterwards.
- ex_ovf (ex_pc=0x20) and id_illegal (id_pc=0x24) in the same cycle -> cause=12, epc=0x20, flush_ex=1.
- irq=1, id_pc=0x30 (EXC_IRQ_EN defined) -> cause=0, epc=0x30, flush_ex=0. On ERET -> pc_redirect=0x30. Repeat with the macro undefined -> no redirect, in_handler stays 0.
- id_illegal (id_pc=0x8), then id_illegal again while in HANDLER -> dbl_fault=1 and stays 1; epc remains 0x8.
- Enter HANDLER via id_illegal, assert reset for 1 cycle -> next cycle in_handler=0, dbl_fault=0, epc=0, pc_sel=0. A subsequent id_eret produces no redirect.
